// File: rtl/receptor_torreta_pkg.sv
// Shared constants for the turret serial receiver.
// ASCII codes, message length, byte FSM encodings and helpers.
package receptor_torreta_pkg;

  localparam int CLKS_PER_BIT_PADRAO = 434;
  localparam int TAM_MENSAGEM        = 8;

  localparam logic [6:0] ASCII_ZERO      = 7'h30;
  localparam logic [6:0] ASCII_NOVE      = 7'h39;
  localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
  localparam logic [6:0] ASCII_CERQUILHA = 7'h23;

  localparam logic [3:0] ST_INICIAL         = 4'd0;
  localparam logic [3:0] ST_ESPERA_START    = 4'd1;
  localparam logic [3:0] ST_MEIO_START      = 4'd2;
  localparam logic [3:0] ST_RECEBE_DADOS    = 4'd3;
  localparam logic [3:0] ST_RECEBE_PARIDADE = 4'd4;
  localparam logic [3:0] ST_RECEBE_STOP     = 4'd5;
  localparam logic [3:0] ST_FIM_BYTE        = 4'd6;

  function automatic logic eh_digito(input logic [6:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
  endfunction

  function automatic logic [3:0] valor_digito(input logic [6:0] c);
    logic [6:0] v;
    v = c - ASCII_ZERO;
    return v[3:0];
  endfunction

endpackage

// File: rtl/receptor_serial_7E2.sv
// Byte receiver: 1 start, 7 data LSB first, even parity, 2 stop.
// Emits one-cycle byte_pronto / byte_erro after the first stop bit.
module receptor_serial_7E2
  import receptor_torreta_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       byte_pronto,
  output logic       byte_erro,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] FIM_BIT  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] FIM_MEIO = TW'(CLKS_PER_BIT / 2 - 1);

  logic          sync0;
  logic          sync1;
  logic          sync_ant;
  logic [3:0]    estado;
  logic [TW-1:0] timer;
  logic [2:0]    n_bits;
  logic [6:0]    sr;
  logic          bit_par;
  logic          queda;
  logic          fim_bit;

  assign queda     = sync_ant & ~sync1;
  assign fim_bit   = (timer == FIM_BIT);
  assign dado      = sr;
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0       <= 1'b1;
      sync1       <= 1'b1;
      sync_ant    <= 1'b1;
      estado      <= ST_INICIAL;
      timer       <= '0;
      n_bits      <= '0;
      sr          <= '0;
      bit_par     <= 1'b0;
      byte_pronto <= 1'b0;
      byte_erro   <= 1'b0;
    end else begin
      sync0       <= entrada_serial;
      sync1       <= sync0;
      sync_ant    <= sync1;
      byte_pronto <= 1'b0;
      byte_erro   <= 1'b0;
      case (estado)
        ST_INICIAL: estado <= ST_ESPERA_START;
        ST_ESPERA_START: begin
          if (queda) begin
            estado <= ST_MEIO_START;
            timer  <= '0;
          end
        end
        ST_MEIO_START: begin
          if (timer == FIM_MEIO) begin
            timer  <= '0;
            n_bits <= '0;
            estado <= sync1 ? ST_ESPERA_START : ST_RECEBE_DADOS;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RECEBE_DADOS: begin
          if (fim_bit) begin
            timer  <= '0;
            sr     <= {sync1, sr[6:1]};
            n_bits <= n_bits + 3'd1;
            if (n_bits == 3'd6) estado <= ST_RECEBE_PARIDADE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RECEBE_PARIDADE: begin
          if (fim_bit) begin
            timer   <= '0;
            bit_par <= sync1;
            estado  <= ST_RECEBE_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RECEBE_STOP: begin
          if (fim_bit) begin
            timer  <= '0;
            estado <= ST_FIM_BYTE;
            // second stop bit is left as idle time
            if (sync1 && !(^{sr, bit_par})) byte_pronto <= 1'b1;
            else                            byte_erro   <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_FIM_BYTE: estado <= ST_ESPERA_START;
        default:     estado <= ST_INICIAL;
      endcase
    end
  end

endmodule

// File: rtl/receptor_torreta.sv
// Turret message parser: "ABC,DEF#" -> angle and distance BCD digits.
// Outputs only change on a complete, well-formed message.
module receptor_torreta
  import receptor_torreta_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [3:0] angulo_centena,
  output logic [3:0] angulo_dezena,
  output logic [3:0] angulo_unidade,
  output logic [3:0] distancia_centena,
  output logic [3:0] distancia_dezena,
  output logic [3:0] distancia_unidade,
  output logic       mensagem_pronta,
  output logic       erro_paridade,
  output logic       erro_formato,
  output logic [3:0] db_estado
);

  logic [6:0] dado;
  logic       byte_pronto;
  logic       byte_erro;
  logic [2:0] indice;
  logic [2:0] slot;
  logic [3:0] sombra [6];
  logic       eh_cerq;
  logic       legal;

  receptor_serial_7E2 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serial (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dado           (dado),
    .byte_pronto    (byte_pronto),
    .byte_erro      (byte_erro),
    .db_estado      (db_estado)
  );

  assign eh_cerq = (dado == ASCII_CERQUILHA);
  // the comma slot is skipped in the shadow array
  assign slot = (indice > 3'd3) ? indice - 3'd1 : indice;

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (indice == 3'd3): legal = (dado == ASCII_VIRGULA);
      (indice == 3'd7): legal = eh_cerq;
      default:          legal = eh_digito(dado);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      indice            <= '0;
      angulo_centena    <= '0;
      angulo_dezena     <= '0;
      angulo_unidade    <= '0;
      distancia_centena <= '0;
      distancia_dezena  <= '0;
      distancia_unidade <= '0;
      mensagem_pronta   <= 1'b0;
      erro_paridade     <= 1'b0;
      erro_formato      <= 1'b0;
      for (int i = 0; i < 6; i++) sombra[i] <= '0;
    end else begin
      mensagem_pronta <= 1'b0;
      erro_paridade   <= 1'b0;
      erro_formato    <= 1'b0;
      if (byte_erro) begin
        erro_paridade <= 1'b1;
        indice        <= '0;
      end else if (byte_pronto) begin
        if (eh_cerq) begin
          indice <= '0;
          if (indice == 3'(TAM_MENSAGEM - 1)) begin
            angulo_centena    <= sombra[0];
            angulo_dezena     <= sombra[1];
            angulo_unidade    <= sombra[2];
            distancia_centena <= sombra[3];
            distancia_dezena  <= sombra[4];
            distancia_unidade <= sombra[5];
            mensagem_pronta   <= 1'b1;
          end else begin
            erro_formato <= 1'b1;
          end
        end else if (legal) begin
          if (indice != 3'd3) sombra[slot] <= valor_digito(dado);
          indice <= indice + 3'd1;
        end else begin
          erro_formato <= 1'b1;
          indice       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_receptor_torreta.sv
// Bench for receptor_torreta: directed scenarios plus random messages
// checked every cycle against a message-level reference model.
module tb_receptor_torreta;

  localparam int N = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       entrada_serial = 1'b1;
  logic [3:0] angulo_centena, angulo_dezena, angulo_unidade;
  logic [3:0] distancia_centena, distancia_dezena, distancia_unidade;
  logic       mensagem_pronta, erro_paridade, erro_formato;
  logic [3:0] db_estado;

  receptor_torreta #(.CLKS_PER_BIT(N)) dut (
    .clock             (clock),
    .reset             (reset),
    .entrada_serial    (entrada_serial),
    .angulo_centena    (angulo_centena),
    .angulo_dezena     (angulo_dezena),
    .angulo_unidade    (angulo_unidade),
    .distancia_centena (distancia_centena),
    .distancia_dezena  (distancia_dezena),
    .distancia_unidade (distancia_unidade),
    .mensagem_pronta   (mensagem_pronta),
    .erro_paridade     (erro_paridade),
    .erro_formato      (erro_formato),
    .db_estado         (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tipo;
    logic [23:0] dig;
  } evento_t;

  evento_t     fila[$];
  logic [7:0]  msg_buf[$];
  logic [23:0] commit = '0;
  logic [23:0] saida;
  evento_t     ev;
  int          tipo_obs;
  int checks = 0;
  int errors = 0;
  int n_pronta = 0, n_par = 0, n_fmt = 0;
  int p0, q0, f0;

  assign saida = {angulo_centena, angulo_dezena, angulo_unidade,
                  distancia_centena, distancia_dezena, distancia_unidade};

  function automatic logic [3:0] val(input logic [7:0] b);
    logic [7:0] v;
    v = b - 8'h30;
    return v[3:0];
  endfunction

  // reference: what each received byte must produce at message level
  task automatic model_byte(input logic [7:0] c, input bit bad);
    int pos;
    pos = msg_buf.size();
    if (bad) begin
      fila.push_back('{tipo: 1, dig: 24'h0});
      msg_buf.delete();
    end else if (c == 8'h23) begin
      if (pos == 7)
        fila.push_back('{tipo: 0, dig: {val(msg_buf[0]), val(msg_buf[1]),
                         val(msg_buf[2]), val(msg_buf[4]), val(msg_buf[5]),
                         val(msg_buf[6])}});
      else
        fila.push_back('{tipo: 2, dig: 24'h0});
      msg_buf.delete();
    end else if ((pos == 3 && c == 8'h2C) ||
                 (pos != 3 && pos < 7 && c >= 8'h30 && c <= 8'h39)) begin
      msg_buf.push_back(c);
    end else begin
      fila.push_back('{tipo: 2, dig: 24'h0});
      msg_buf.delete();
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mensagem_pronta || erro_paridade || erro_formato) begin
        tipo_obs = mensagem_pronta ? 0 : (erro_paridade ? 1 : 2);
        if (tipo_obs == 0) n_pronta++;
        else if (tipo_obs == 1) n_par++;
        else n_fmt++;
        checks++;
        if (fila.size() == 0) begin
          errors++;
          $display("FAIL evento_inesperado: got tipo %0d, expected none t=%0t",
                   tipo_obs, $time);
        end else begin
          ev = fila.pop_front();
          if (ev.tipo != tipo_obs) begin
            errors++;
            $display("FAIL tipo_evento: got %0d, expected %0d t=%0t",
                     tipo_obs, ev.tipo, $time);
          end
          checks++;
          if (tipo_obs == 0) begin
            if (saida !== ev.dig) begin
              errors++;
              $display("FAIL saida_pronta: got %h, expected %h", saida, ev.dig);
            end
            commit = ev.dig;
          end else if (saida !== commit) begin
            errors++;
            $display("FAIL saida_em_erro: got %h, expected %h", saida, commit);
          end
        end
      end else begin
        checks++;
        if (saida !== commit) begin
          errors++;
          if (errors < 30)
            $display("FAIL saida_estavel: got %h, expected %h t=%0t",
                     saida, commit, $time);
        end
      end
    end
  end

  task automatic chk(input string nome, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nome, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bit_tx(input logic v);
    entrada_serial = v;
    idle(N);
  endtask

  task automatic send_byte(input logic [7:0] c, input bit bad_par,
                           input bit bad_stop);
    model_byte(c, bad_par || bad_stop);
    bit_tx(1'b0);
    for (int i = 0; i < 7; i++) bit_tx(c[i]);
    bit_tx((^c[6:0]) ^ bad_par);
    bit_tx(!bad_stop);
    bit_tx(1'b1);
  endtask

  task automatic send_msg(input string s, input int bad_pos);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], i == bad_pos, 1'b0);
  endtask

  task automatic reset_dut();
    entrada_serial = 1'b1;
    reset = 1'b1;
    fila.delete();
    msg_buf.delete();
    commit = '0;
    idle(3);
    chk("reset_estado", 32'(db_estado), 32'd0);
    chk("reset_saida", 32'(saida), 32'd0);
    reset = 1'b0;
    idle(3);
    chk("espera_start", 32'(db_estado), 32'd1);
  endtask

  task automatic snap();
    p0 = n_pronta;
    q0 = n_par;
    f0 = n_fmt;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] c;
    int r;
    reset_dut();

    snap();
    send_msg("090,035#", -1);
    idle(4);
    chk("t1_pronta", n_pronta - p0, 1);
    chk("t1_erros", (n_par - q0) + (n_fmt - f0), 0);
    chk("t1_saida", 32'(saida), 32'h090035);

    snap();
    send_msg("120,0", 2);
    send_byte(8'h23, 1'b0, 1'b0);
    chk("t2_saida_antes", 32'(saida), 32'h090035);
    send_msg("045,200#", -1);
    idle(4);
    chk("t2_paridade", n_par - q0, 1);
    chk("t2_pronta", n_pronta - p0, 1);
    chk("t2_saida", 32'(saida), 32'h045200);

    snap();
    send_msg("09A,010#", -1);
    idle(4);
    chk("t3_formato", n_fmt - f0, 3);
    chk("t3_pronta", n_pronta - p0, 0);
    chk("t3_saida", 32'(saida), 32'h045200);

    snap();
    entrada_serial = 1'b0;
    idle(N / 4);
    entrada_serial = 1'b1;
    idle(2 * N);
    chk("t4_pulsos", (n_pronta - p0) + (n_par - q0) + (n_fmt - f0), 0);
    chk("t4_estado", 32'(db_estado), 32'd1);

    send_msg("180,", -1);
    entrada_serial = 1'b0;
    idle(3 * N);
    reset_dut();
    snap();
    send_msg("180,100#", -1);
    idle(4);
    chk("t5_pronta", n_pronta - p0, 1);
    chk("t5_saida", 32'(saida), 32'h180100);

    snap();
    send_msg("001,002#", -1);
    send_msg("003,004#", -1);
    idle(4);
    chk("t6_pronta", n_pronta - p0, 2);
    chk("t6_saida", 32'(saida), 32'h003004);

    for (int m = 0; m < 14; m++) begin
      for (int p = 0; p < 8; p++) begin
        if (p == 3) c = 8'h2C;
        else if (p == 7) c = 8'h23;
        else c = 8'(8'h30 + $urandom_range(0, 9));
        r = $urandom_range(0, 39);
        if (r == 0) send_byte(c, 1'b1, 1'b0);
        else if (r == 1) send_byte(c, 1'b0, 1'b1);
        else if (r == 2) send_byte(8'($urandom_range(0, 127)), 1'b0, 1'b0);
        else if (r == 3) send_byte(8'h23, 1'b0, 1'b0);
        else send_byte(c, 1'b0, 1'b0);
      end
    end
    idle(4 * N);
    chk("fila_vazia", fila.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receptor_torreta.md
RECEPTOR_TORRETA -- requirements
Module: receptor_torreta

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 clock  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 entrada_serial  input  1  asynchronous serial line from the turret; idle high.
REQ-005 angulo_centena, angulo_dezena, angulo_unidade  output  4 each  BCD digits of last valid angle.
REQ-006 distancia_centena, distancia_dezena, distancia_unidade  output  4 each  BCD digits of last valid distance.
REQ-007 mensagem_pronta  output  1  one-cycle pulse when a complete valid message is latched.
REQ-008 erro_paridade  output  1  one-cycle pulse on parity or stop-bit error.
REQ-009 erro_formato  output  1  one-cycle pulse on a character illegal at its message position.
REQ-010 db_estado  output  4  encoded byte-receiver state for the hexa7seg debug display.

Function
REQ-011 The receiver SHALL pass entrada_serial through a 2-flop synchronizer before any use.
REQ-012 Frame format SHALL be: 1 start (0), 7 data bits LSB first, 1 even-parity bit, 2 stop bits (1).
REQ-013 Byte FSM states SHALL be inicial, espera_start, meio_start, recebe_dados, recebe_paridade, recebe_stop, fim_byte.
REQ-014 In espera_start a synchronized 1->0 transition SHALL enter meio_start and clear the bit-timer.
REQ-015 After CLKS_PER_BIT/2 cycles in meio_start the line SHALL be resampled; high -> back to espera_start (glitch), low -> recebe_dados.
REQ-016 Each data, parity and stop bit SHALL be sampled once, CLKS_PER_BIT cycles after the previous sample.
REQ-017 Parity SHALL be checked as XOR of 7 data bits plus parity bit == 0; failure flags the byte as bad.
REQ-018 Only the first stop bit SHALL be checked; 0 flags the byte as bad; FSM returns to espera_start right after that sample, so the second stop bit is idle time.
REQ-019 Message format SHALL be 8 ASCII chars "ABC,DEF#": positions 0-2 and 4-6 in 0x30-0x39, position 3 = 0x2C, position 7 = 0x23.
REQ-020 A 3-bit position index SHALL advance by one per good byte and reset to 0 after position 7.
REQ-021 Digit bytes SHALL be held in a shadow register as value minus 0x30 (4 bits).
REQ-022 On position 7 matching '#', the six shadow digits SHALL be copied to the outputs and mensagem_pronta pulsed in the same cycle, one cycle after the stop-bit sample.
REQ-023 A bad byte SHALL pulse erro_paridade, discard the partial message, and set the index to 0.
REQ-024 A good byte illegal at its position SHALL pulse erro_formato, discard the partial message, and set the index to 0.
REQ-025 Exception: a good '#' at any position SHALL set the index to 0 (resync); if not at position 7 it also pulses erro_formato.
REQ-026 Outputs SHALL hold the last valid message indefinitely; erroneous or partial messages never alter them.
REQ-027 Back-to-back frames with zero idle beyond the second stop bit SHALL be received without loss.

Reset
REQ-028 Reset SHALL force FSM to inicial (leaving to espera_start next cycle), index 0, all digit outputs 0, all pulses 0, synchronizer flops 1.
REQ-029 Reset mid-frame or mid-message SHALL discard all partial data; the next complete frame after reset is decoded normally.

Structure
REQ-030 A shared package SHALL hold ASCII constants (0x30, 0x39, 0x2C, 0x23), message length 8, FSM state encodings, and default CLKS_PER_BIT.
REQ-031 The byte FSM SHALL be a sub-module receptor_serial_7E2 (outputs: dado[6:0], byte_pronto, byte_erro, db_estado); receptor_torreta holds the message parser.

Verification
REQ-032 Send "090,035#" -> one mensagem_pronta pulse; angulo 0/9/0; distancia 0/3/5; no error pulses.
REQ-033 Send "120,0" with bad parity on char 2, then "045,200#" -> erro_paridade once; outputs unchanged until the pulse for 045/200.
REQ-034 Send "09A,010#" -> erro_formato at char 2; no mensagem_pronta; outputs keep prior values.
REQ-035 Low glitch of CLKS_PER_BIT/4 cycles on idle line -> no byte, no pulses, FSM back in espera_start.
REQ-036 Reset after 4 chars of "180,100#", then send "180,100#" -> exactly one mensagem_pronta with 1/8/0 and 1/0/0.
REQ-037 Send "001,002#" and "003,004#" back-to-back -> two mensagem_pronta pulses, final outputs 0/0/3 and 0/0/4.
